// File: rtl/expr_stream_checker.sv
// Byte-serial syntax checker for arithmetic expressions: term (op term)*, term := number | '(' expr ')'.
// Registered verdict, sticky error with the position of the first offending character.
module expr_stream_checker #(
  parameter int unsigned MAX_DEPTH        = 7,
  parameter int unsigned DEPTH_W          = 3,
  parameter int unsigned POS_W            = 8,
  parameter bit          ALLOW_MULTIDIGIT = 1'b1,
  parameter bit          ALLOW_MINUS      = 1'b1,
  parameter bit          IGNORE_SPACE     = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [POS_W-1:0]   char_cnt,
  output logic [POS_W-1:0]   err_pos
);

  typedef enum logic [1:0] {
    S_OPND = 2'd0,
    S_NUM  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [DEPTH_W-1:0] MaxDepth = DEPTH_W'(MAX_DEPTH);
  localparam logic [POS_W-1:0]   CntMax   = '1;

  state_e             state_q, state_d;
  logic               last_digit_q, last_digit_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               out_q, out_d;
  logic               err_q, err_d;
  logic [POS_W-1:0]   char_cnt_q, char_cnt_d;
  logic [POS_W-1:0]   err_pos_q, err_pos_d;

  logic is_digit_c, is_op_c, is_lpar_c, is_rpar_c, is_space_c, goto_err_c;

  // Character classification
  always_comb begin
    is_digit_c = (in >= 8'h30) && (in <= 8'h39);
    is_op_c    = (in == 8'h2B) || (in == 8'h2A) || (ALLOW_MINUS && (in == 8'h2D));
    is_lpar_c  = (in == 8'h28);
    is_rpar_c  = (in == 8'h29);
    is_space_c = IGNORE_SPACE && (in == 8'h20);
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_OPND;
      last_digit_q <= 1'b0;
      depth_q      <= '0;
      out_q        <= 1'b0;
      err_q        <= 1'b0;
      char_cnt_q   <= '0;
      err_pos_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_digit_q <= last_digit_d;
      depth_q      <= depth_d;
      out_q        <= out_d;
      err_q        <= err_d;
      char_cnt_q   <= char_cnt_d;
      err_pos_q    <= err_pos_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_digit_d = last_digit_q;
    depth_d      = depth_q;
    out_d        = out_q;
    err_d        = err_q;
    char_cnt_d   = char_cnt_q;
    err_pos_d    = err_pos_q;
    goto_err_c   = 1'b0;

    if (in_valid) begin
      if (char_cnt_q != CntMax) char_cnt_d = char_cnt_q + POS_W'(1);

      // An ignored space leaves state, depth and last_digit untouched
      if (!is_space_c) begin
        case (state_q)
          S_OPND: begin
            if (is_digit_c) begin
              state_d      = S_NUM;
              last_digit_d = 1'b1;
            end else if (is_lpar_c && (depth_q < MaxDepth)) begin
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              goto_err_c = 1'b1;
            end
          end
          S_NUM: begin
            if (is_digit_c) begin
              if (!(ALLOW_MULTIDIGIT && last_digit_q)) goto_err_c = 1'b1;
            end else if (is_op_c) begin
              state_d      = S_OPND;
              last_digit_d = 1'b0;
            end else if (is_rpar_c && (depth_q != '0)) begin
              depth_d      = depth_q - DEPTH_W'(1);
              last_digit_d = 1'b0;
            end else begin
              goto_err_c = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (goto_err_c) begin
        state_d   = S_ERR;
        err_d     = 1'b1;
        err_pos_d = char_cnt_q;
      end

      out_d = (state_d == S_NUM) && (depth_d == '0);
    end
  end

  assign out      = out_q;
  assign err      = err_q;
  assign depth    = depth_q;
  assign char_cnt = char_cnt_q;
  assign err_pos  = err_pos_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Scoreboarded random/directed bench for expr_stream_checker, two parameter sets sharing one stream.
module tb_expr_stream_checker;

  typedef struct {
    bit out;
    bit err;
    int depth;
    int cnt;
    int epos;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;
  bit         done = 1'b0;
  logic       fire;

  logic       out_a, err_a, out_b, err_b;
  logic [2:0] depth_a, depth_b;
  logic [7:0] cnt_a, cnt_b, pos_a, pos_b;

  logic [7:0] hist[$];
  exp_t       qa[$], qb[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  expr_stream_checker u_a (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .out(out_a), .err(err_a), .depth(depth_a), .char_cnt(cnt_a), .err_pos(pos_a)
  );

  expr_stream_checker #(
    .MAX_DEPTH(2), .DEPTH_W(3), .POS_W(8),
    .ALLOW_MULTIDIGIT(1'b0), .ALLOW_MINUS(1'b0), .IGNORE_SPACE(1'b1)
  ) u_b (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .out(out_b), .err(err_b), .depth(depth_b), .char_cnt(cnt_b), .err_pos(pos_b)
  );

  // Reference: rescan the whole stream since the last clear against the grammar rules
  function automatic exp_t ref_scan(input logic [7:0] s[$], input int maxd,
                                    input bit multi, input bit minus, input bit space);
    exp_t r;
    int   d = 0;
    bit   need_opnd = 1'b1;
    bit   prev_digit = 1'b0;
    bit   bad = 1'b0;
    int   epos = 0;
    for (int i = 0; i < s.size(); i++) begin
      logic [7:0] ch;
      bit isd, isop;
      ch = s[i];
      if (bad) continue;
      if (space && ch == " ") continue;
      isd  = (ch >= "0") && (ch <= "9");
      isop = (ch == "+") || (ch == "*") || (minus && ch == "-");
      if (need_opnd) begin
        if (isd) begin
          need_opnd = 1'b0;
          prev_digit = 1'b1;
        end else if (ch == "(" && d < maxd) d++;
        else begin bad = 1'b1; epos = i; end
      end else begin
        if (isd && multi && prev_digit) begin
        end else if (isop) begin
          need_opnd = 1'b1;
          prev_digit = 1'b0;
        end else if (ch == ")" && d > 0) begin
          d--;
          prev_digit = 1'b0;
        end else begin bad = 1'b1; epos = i; end
      end
    end
    r.out   = (s.size() > 0) && !bad && !need_opnd && (d == 0);
    r.err   = bad;
    r.depth = d;
    r.cnt   = (s.size() > 255) ? 255 : s.size();
    r.epos  = (epos > 255) ? 255 : epos;
    return r;
  endfunction

  function automatic exp_t zero_exp();
    exp_t r;
    r.out = 1'b0; r.err = 1'b0; r.depth = 0; r.cnt = 0; r.epos = 0;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic o, input logic e, input logic [2:0] d,
                     input logic [7:0] c, input logic [7:0] p, input exp_t x);
    checks++;
    if (o !== 1'(x.out) || e !== 1'(x.err) || d !== 3'(x.depth) ||
        c !== 8'(x.cnt) || p !== 8'(x.epos)) begin
      errors++;
      $display("FAIL %s @%0t: got out=%0b err=%0b depth=%0d cnt=%0d pos=%0d, want out=%0b err=%0b depth=%0d cnt=%0d pos=%0d",
               nm, $time, o, e, d, c, p, x.out, x.err, x.depth, x.cnt, x.epos);
    end
  endtask

  always @(posedge clk or posedge clr) begin
    if (clr) fire <= 1'b0;
    else     fire <= in_valid;
  end

  // Monitor: pops one expectation per consumed char, checks holding values otherwise
  initial begin : monitor
    exp_t la, lb;
    la = zero_exp();
    lb = zero_exp();
    forever begin
      @(negedge clk or posedge clr or posedge done);
      if (done) begin
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
          errors++;
          $display("FAIL leftover: got %0d/%0d queued, want 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end else if (clr) begin
        #1;
        la = zero_exp();
        lb = zero_exp();
        cmp("clr_a", out_a, err_a, depth_a, cnt_a, pos_a, la);
        cmp("clr_b", out_b, err_b, depth_b, cnt_b, pos_b, lb);
      end else begin
        if (fire) begin
          if (qa.size() == 0 || qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL underflow: got %0d/%0d queued, want >0", qa.size(), qb.size());
          end else begin
            la = qa.pop_front();
            lb = qb.pop_front();
          end
        end
        cmp("cfg_a", out_a, err_a, depth_a, cnt_a, pos_a, la);
        cmp("cfg_b", out_b, err_b, depth_b, cnt_b, pos_b, lb);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] ch);
    @(posedge clk); #1;
    in = ch;
    in_valid = 1'b1;
    hist.push_back(ch);
    qa.push_back(ref_scan(hist, 7, 1'b1, 1'b1, 1'b0));
    qb.push_back(ref_scan(hist, 2, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  // Pulse clr between edges once the last consumed char has been checked
  task automatic do_clr();
    idle(2);
    clr = 1'b1;
    hist.delete();
    #2;
    clr = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    int r;
    string digits;
    logic [7:0] ch;
    digits = "0123456789";
    r = $urandom_range(0, 99);
    if (r < 40)      ch = digits[$urandom_range(0, 9)];
    else if (r < 50) ch = "+";
    else if (r < 57) ch = "*";
    else if (r < 64) ch = "-";
    else if (r < 76) ch = "(";
    else if (r < 88) ch = ")";
    else if (r < 95) ch = " ";
    else             ch = 8'($urandom_range(8'h3A, 8'h7E));
    return ch;
  endfunction

  initial begin : driver
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    idle(2);

    send_str("12+(3*4)", 0);
    do_clr();
    send_str("(((x5", 0);
    do_clr();
    send_str(")5", 0);
    do_clr();
    send_str("12", 0);
    do_clr();
    send_str("3-1", 0);
    do_clr();
    send_str("1+2", 3);
    do_clr();
    send_str("(1+", 0);
    do_clr();
    send_str("7", 0);
    do_clr();
    send_str("1 2", 0);
    do_clr();
    send_str("( 3 ) * (4-2)", 1);
    do_clr();
    send_str("((8))", 0);
    do_clr();

    for (int t = 0; t < 800; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6)       do_clr();
      else if (r < 18) idle($urandom_range(1, 3));
      else             send(pick());
    end

    // Counter saturation and err_pos capturing the saturated count
    do_clr();
    for (int i = 0; i < 150; i++) send_str("1+", 0);
    send(")");
    send("4");
    idle(3);

    done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL timeout: got no summary, want summary");
    $fatal(1);
  end

endmodule
